// File: rtl/calc_sched.sv
// calc_sched: round-robin front end for a shared external combinational
// calculator. Two requesters compete for one calculator; the winning
// operands are latched and driven out, the result is sampled after CALC_LAT
// settle cycles, and it is returned on a valid/ready response channel.
module calc_sched #(
  parameter int unsigned CALC_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic signed [7:0] req0_a,
  input  logic signed [7:0] req0_b,
  input  logic        [1:0] req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic signed [7:0] req1_a,
  input  logic signed [7:0] req1_b,
  input  logic        [1:0] req1_op,
  output logic        [7:0] calc_a,
  output logic        [7:0] calc_b,
  output logic        [1:0] calc_op,
  input  logic signed [7:0] calc_result,
  input  logic              calc_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic        [7:0] rsp_result,
  output logic              rsp_overflow,
  output logic              rsp_divzero,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] waitCnt_q, waitCnt_d;
  logic       prio_q, prio_d;
  logic [7:0] opA_q, opA_d;
  logic [7:0] opB_q, opB_d;
  logic [1:0] opCode_q, opCode_d;
  logic       reqId_q, reqId_d;
  logic       rspId_q, rspId_d;
  logic [7:0] rspResult_q, rspResult_d;
  logic       rspOverflow_q, rspOverflow_d;
  logic       rspDivzero_q, rspDivzero_d;
  logic       grantValid;
  logic       grantId;
  logic       divZero;

  // The calculator only ever sees latched operands, so its inputs cannot
  // wiggle while a requester changes its request lines.
  assign calc_a       = opA_q;
  assign calc_b       = opB_q;
  assign calc_op      = opCode_q;
  assign rsp_valid    = (state_q == RESP);
  assign rsp_id       = rspId_q;
  assign rsp_result   = rspResult_q;
  assign rsp_overflow = rspOverflow_q;
  assign rsp_divzero  = rspDivzero_q;
  assign busy         = (state_q != IDLE);
  assign divZero      = (opCode_q == 2'b11) && (opB_q == 8'd0);

  // Round-robin grant: a lone requester wins, on contention prio_q decides.
  always_comb begin
    grantValid = req0_valid | req1_valid;
    grantId    = (req0_valid & req1_valid) ? prio_q : req1_valid;
    req0_ready = (state_q == IDLE) & grantValid & ~grantId;
    req1_ready = (state_q == IDLE) & grantValid & grantId;
  end

  // Next-state logic: accept in IDLE, count down in WAIT, hand off in RESP.
  always_comb begin
    state_d       = state_q;
    waitCnt_d     = waitCnt_q;
    prio_d        = prio_q;
    opA_d         = opA_q;
    opB_d         = opB_q;
    opCode_d      = opCode_q;
    reqId_d       = reqId_q;
    rspId_d       = rspId_q;
    rspResult_d   = rspResult_q;
    rspOverflow_d = rspOverflow_q;
    rspDivzero_d  = rspDivzero_q;
    unique case (state_q)
      IDLE: begin
        if (grantValid) begin
          opA_d     = grantId ? req1_a : req0_a;
          opB_d     = grantId ? req1_b : req0_b;
          opCode_d  = grantId ? req1_op : req0_op;
          reqId_d   = grantId;
          prio_d    = ~grantId;
          waitCnt_d = 3'(CALC_LAT);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (waitCnt_q == 3'd0) begin
          rspId_d = reqId_q;
          if (divZero) begin
            rspResult_d   = 8'd0;
            rspOverflow_d = 1'b1;
            rspDivzero_d  = 1'b1;
          end else begin
            rspResult_d   = calc_result;
            rspOverflow_d = calc_overflow;
            rspDivzero_d  = 1'b0;
          end
          state_d = RESP;
        end else begin
          waitCnt_d = waitCnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      waitCnt_q     <= 3'd0;
      prio_q        <= 1'b0;
      opA_q         <= 8'd0;
      opB_q         <= 8'd0;
      opCode_q      <= 2'b00;
      reqId_q       <= 1'b0;
      rspId_q       <= 1'b0;
      rspResult_q   <= 8'd0;
      rspOverflow_q <= 1'b0;
      rspDivzero_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      waitCnt_q     <= waitCnt_d;
      prio_q        <= prio_d;
      opA_q         <= opA_d;
      opB_q         <= opB_d;
      opCode_q      <= opCode_d;
      reqId_q       <= reqId_d;
      rspId_q       <= rspId_d;
      rspResult_q   <= rspResult_d;
      rspOverflow_q <= rspOverflow_d;
      rspDivzero_q  <= rspDivzero_d;
    end
  end

endmodule

// File: tb/tb_calc_sched.sv
// tb_calc_sched: scoreboard bench for calc_sched. Two instances are built,
// one with CALC_LAT=1 (index 0) and one with CALC_LAT=3 (index 1), each with
// its own behavioural calculator. Stimulus pushes hand-computed responses
// into a per-instance queue; a monitor pops and compares on each handshake.
module tb_calc_sched;

  typedef struct {
    logic       id;
    logic [7:0] result;
    logic       ovf;
    logic       dz;
    int         acceptEdge;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  logic       reqValid [2][2];
  logic       reqReady [2][2];
  logic [7:0] reqA     [2][2];
  logic [7:0] reqB     [2][2];
  logic [1:0] reqOp    [2][2];
  logic [7:0] calcA    [2];
  logic [7:0] calcB    [2];
  logic [1:0] calcOp   [2];
  logic [7:0] calcRes  [2];
  logic       calcOvf  [2];
  logic       rspValid [2];
  logic       rspReady [2];
  logic       rspId    [2];
  logic [7:0] rspResult[2];
  logic       rspOverflow[2];
  logic       rspDivzero[2];
  logic       busy     [2];

  exp_t expQ[2][$];

  int  grants;
  bit  seen;

  // Free-running clock.
  always #5 clk = ~clk;

  // Counts rising edges so latency can be measured from the negedge side.
  always @(posedge clk) cyc <= cyc + 1;

  calc_sched #(.CALC_LAT(1)) dutL1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(reqValid[0][0]), .req0_ready(reqReady[0][0]),
    .req0_a(reqA[0][0]), .req0_b(reqB[0][0]), .req0_op(reqOp[0][0]),
    .req1_valid(reqValid[0][1]), .req1_ready(reqReady[0][1]),
    .req1_a(reqA[0][1]), .req1_b(reqB[0][1]), .req1_op(reqOp[0][1]),
    .calc_a(calcA[0]), .calc_b(calcB[0]), .calc_op(calcOp[0]),
    .calc_result(calcRes[0]), .calc_overflow(calcOvf[0]),
    .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]), .rsp_id(rspId[0]),
    .rsp_result(rspResult[0]), .rsp_overflow(rspOverflow[0]),
    .rsp_divzero(rspDivzero[0]), .busy(busy[0])
  );

  calc_sched #(.CALC_LAT(3)) dutL3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(reqValid[1][0]), .req0_ready(reqReady[1][0]),
    .req0_a(reqA[1][0]), .req0_b(reqB[1][0]), .req0_op(reqOp[1][0]),
    .req1_valid(reqValid[1][1]), .req1_ready(reqReady[1][1]),
    .req1_a(reqA[1][1]), .req1_b(reqB[1][1]), .req1_op(reqOp[1][1]),
    .calc_a(calcA[1]), .calc_b(calcB[1]), .calc_op(calcOp[1]),
    .calc_result(calcRes[1]), .calc_overflow(calcOvf[1]),
    .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]), .rsp_id(rspId[1]),
    .rsp_result(rspResult[1]), .rsp_overflow(rspOverflow[1]),
    .rsp_divzero(rspDivzero[1]), .busy(busy[1])
  );

  // Behavioural calculator: {overflow, 8-bit result}. Divide by zero returns
  // a junk value with no overflow so the block's own override is visible.
  function automatic logic [8:0] calcModel(input logic signed [7:0] a,
                                           input logic signed [7:0] b,
                                           input logic [1:0] op);
    logic signed [15:0] full;
    full = 16'sd0;
    case (op)
      2'b00: full = a + b;
      2'b01: full = a - b;
      2'b10: full = a * b;
      default: begin
        if (b == 8'sd0) return {1'b0, 8'h5A};
        if (a == -8'sd128 && b == -8'sd1) return {1'b1, 8'h80};
        full = a / b;
      end
    endcase
    return {full != {{8{full[7]}}, full[7:0]}, full[7:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkReset(input int inst);
    checkOutput("rst_rsp_valid", 32'(rspValid[inst]), 0);
    checkOutput("rst_busy", 32'(busy[inst]), 0);
    checkOutput("rst_calc_a", 32'(calcA[inst]), 0);
    checkOutput("rst_calc_b", 32'(calcB[inst]), 0);
    checkOutput("rst_calc_op", 32'(calcOp[inst]), 0);
    checkOutput("rst_rsp_id", 32'(rspId[inst]), 0);
    checkOutput("rst_rsp_result", 32'(rspResult[inst]), 0);
    checkOutput("rst_rsp_overflow", 32'(rspOverflow[inst]), 0);
    checkOutput("rst_rsp_divzero", 32'(rspDivzero[inst]), 0);
  endtask

  // Drive one request, wait (bounded) for its grant, record the expectation.
  task automatic applyStimulus(input int inst, input int id,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [1:0] op, input logic [7:0] expRes,
                               input logic expOvf, input logic expDz);
    exp_t e;
    bit   done;
    done = 1'b0;
    reqA[inst][id]     = a;
    reqB[inst][id]     = b;
    reqOp[inst][id]    = op;
    reqValid[inst][id] = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (reqReady[inst][id]) begin
        e.id         = id[0];
        e.result     = expRes;
        e.ovf        = expOvf;
        e.dz         = expDz;
        e.acceptEdge = cyc + 1;
        expQ[inst].push_back(e);
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    reqValid[inst][id] = 1'b0;
    checkOutput("accepted", 32'(done), 1);
  endtask

  task automatic waitDrain(input int inst);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (expQ[inst].size() == 0 && !rspValid[inst]) ok = 1'b1;
    end
    checkOutput("drain", 32'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  // Calculators and response monitors, one per instance.
  for (genvar g = 0; g < 2; g++) begin : gInst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic prevValid = 1'b0;

    assign {calcOvf[g], calcRes[g]} = calcModel(calcA[g], calcB[g], calcOp[g]);

    // Compare every presented response against the queue head until it is taken.
    always @(negedge clk) begin
      if (rspValid[g]) begin
        if (expQ[g].size() == 0) begin
          checkOutput("unexpected_rsp", 32'(rspValid[g]), 0);
        end else begin
          if (!prevValid)
            checkOutput("latency", 32'(cyc - expQ[g][0].acceptEdge), 32'(LAT + 1));
          checkOutput("rsp_id", 32'(rspId[g]), 32'(expQ[g][0].id));
          checkOutput("rsp_result", 32'(rspResult[g]), 32'(expQ[g][0].result));
          checkOutput("rsp_overflow", 32'(rspOverflow[g]), 32'(expQ[g][0].ovf));
          checkOutput("rsp_divzero", 32'(rspDivzero[g]), 32'(expQ[g][0].dz));
          checkOutput("ready_held_off", 32'({reqReady[g][1], reqReady[g][0]}), 0);
          checkOutput("busy_in_resp", 32'(busy[g]), 1);
          if (rspReady[g]) void'(expQ[g].pop_front());
        end
      end
      prevValid = rspValid[g];
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        reqValid[i][j] = 1'b0;
        reqA[i][j]     = 8'd0;
        reqB[i][j]     = 8'd0;
        reqOp[i][j]    = 2'b00;
      end
      rspReady[i] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkReset(0);
    checkReset(1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 100 + 50 wraps to -106 with overflow.
    applyStimulus(0, 0, 8'd100, 8'd50, 2'b00, 8'h96, 1'b1, 1'b0);
    waitDrain(0);
    // -128 / 0 forced to zero with divzero.
    applyStimulus(0, 1, 8'h80, 8'h00, 2'b11, 8'h00, 1'b1, 1'b1);
    waitDrain(0);
    // 16 * 16 = 256 wraps to 0 with overflow.
    applyStimulus(0, 0, 8'd16, 8'd16, 2'b10, 8'h00, 1'b1, 1'b0);
    waitDrain(0);
    // -128 / -1 overflow comes from the calculator, not divzero.
    applyStimulus(0, 0, 8'h80, 8'hFF, 2'b11, 8'h80, 1'b1, 1'b0);
    waitDrain(0);

    // Both requesters valid continuously after reset: grants 0,1,0,1.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    reqA[0][0] = 8'd3;  reqB[0][0] = 8'd4; reqOp[0][0] = 2'b10;
    reqA[0][1] = 8'hF7; reqB[0][1] = 8'd2; reqOp[0][1] = 2'b11;
    reqValid[0][0] = 1'b1;
    reqValid[0][1] = 1'b1;
    grants = 0;
    for (int i = 0; i < 60 && grants < 4; i++) begin
      @(negedge clk);
      if (reqReady[0][0] | reqReady[0][1]) begin
        exp_t e;
        e.id         = grants[0];
        e.result     = grants[0] ? 8'hFC : 8'h0C;
        e.ovf        = 1'b0;
        e.dz         = 1'b0;
        e.acceptEdge = cyc + 1;
        checkOutput("grant_order", 32'({reqReady[0][1], reqReady[0][0]}),
                    grants[0] ? 32'd2 : 32'd1);
        expQ[0].push_back(e);
        grants++;
      end
    end
    @(posedge clk);
    #1;
    reqValid[0][0] = 1'b0;
    reqValid[0][1] = 1'b0;
    checkOutput("grant_count", 32'(grants), 4);
    waitDrain(0);

    // Response back-pressure for 5 cycles while req1 waits its turn.
    rspReady[0] = 1'b0;
    seen = 1'b0;
    fork
      applyStimulus(0, 0, 8'd5, 8'd7, 2'b00, 8'd12, 1'b0, 1'b0);
      begin
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          if (rspValid[0]) seen = 1'b1;
        end
        checkOutput("rsp_seen", 32'(seen), 1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        rspReady[0] = 1'b1;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(0, 1, 8'd2, 8'd3, 2'b10, 8'd6, 1'b0, 1'b0);
      end
    join
    waitDrain(0);

    // Reset during WAIT aborts the operation without a response.
    applyStimulus(0, 0, 8'd1, 8'd1, 2'b00, 8'd2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    expQ[0].delete();
    checkReset(0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abort_no_rsp", 32'(rspValid[0]), 0);
    end
    @(posedge clk);
    #1;
    // Priority is back on requester 0 even though it was served last.
    reqA[0][1] = 8'hF7; reqB[0][1] = 8'd2; reqOp[0][1] = 2'b11;
    reqValid[0][1] = 1'b1;
    applyStimulus(0, 0, 8'd20, 8'hE2, 2'b00, 8'hF6, 1'b0, 1'b0);
    applyStimulus(0, 1, 8'hF7, 8'd2, 2'b11, 8'hFC, 1'b0, 1'b0);
    waitDrain(0);

    // CALC_LAT=3: 127 - (-128) wraps to -1 with overflow, 4-cycle latency.
    applyStimulus(1, 0, 8'd127, 8'h80, 2'b01, 8'hFF, 1'b1, 1'b0);
    waitDrain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_sched.md
CALC_SCHED -- requirements
Module: calc_sched

Interface
REQ-001 SHALL have parameter CALC_LAT, default 1, meaning cycles allowed for the external combinational calculator to settle (legal 1..7).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports reqN_valid  input  1, reqN_ready  output  1, reqN_a  input  8 (signed), reqN_b  input  8 (signed), reqN_op  input  2 (00 add, 01 sub, 10 mul, 11 div), for N = 0 and 1.
REQ-005 SHALL have ports calc_a  output  8, calc_b  output  8, calc_op  output  2, driving the shared calculator.
REQ-006 SHALL have ports calc_result  input  8 (signed) and calc_overflow  input  1, returned by the shared calculator.
REQ-007 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1, rsp_result  output  8, rsp_overflow  output  1, rsp_divzero  output  1.
REQ-008 SHALL have port busy  output  1, high whenever the state is not IDLE.

Function
REQ-009 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-010 In IDLE, reqN_ready SHALL be high only for the granted requester, combinationally; both ready outputs SHALL be low in WAIT and RESP.
REQ-011 Grant SHALL be round-robin: with one requester valid, grant it; with both valid, grant the one not served last; after reset, requester 0 has priority.
REQ-012 On accept (valid & ready at a rising edge), the FSM SHALL latch a, b, op and the requester id, load the wait counter with CALC_LAT, and move IDLE -> WAIT.
REQ-013 calc_a/calc_b/calc_op SHALL be driven from the latched registers only and SHALL stay stable from accept until the next accept.
REQ-014 In WAIT, the counter SHALL decrement each cycle; at the edge where it reaches 0, the FSM SHALL capture calc_result and calc_overflow into the rsp registers and move WAIT -> RESP.
REQ-015 rsp_valid SHALL rise exactly CALC_LAT+1 cycles after the accept edge.
REQ-016 If latched op = 11 and latched b = 0, the block SHALL set rsp_result = 0, rsp_overflow = 1, rsp_divzero = 1, ignoring the calculator outputs; otherwise rsp_divzero = 0.
REQ-017 In RESP, rsp_valid, rsp_id, rsp_result, rsp_overflow and rsp_divzero SHALL be held stable until rsp_valid & rsp_ready, then go RESP -> IDLE with rsp_valid low the next cycle.
REQ-018 The round-robin "last served" pointer SHALL update on accept, not on response.
REQ-019 Minimum spacing between accepts SHALL be CALC_LAT+3 cycles, given rsp_ready held high.
REQ-020 Requests arriving in WAIT/RESP SHALL be held off (ready low) and never dropped or reordered; a requester's valid withdrawn before accept SHALL be legal.

Reset
REQ-021 On rst_n low, asynchronously: state = IDLE, rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_overflow = 0, rsp_divzero = 0, calc_a = calc_b = 0, calc_op = 00, busy = 0, counter = 0, pointer selects requester 0.
REQ-022 Reset asserted in WAIT or RESP SHALL abort the operation with no response issued; the first accept after deassertion SHALL behave as after power-up.

Verification
REQ-023 CALC_LAT=1, req0 a=100 b=50 op=00, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_id=0, rsp_result=-106, rsp_overflow=1, rsp_divzero=0.
REQ-024 req1 a=-128 b=0 op=11 -> rsp_result=0, rsp_overflow=1, rsp_divzero=1, rsp_id=1.
REQ-025 Both valid continuously after reset, req0 a=3 b=4 op=10, req1 a=-9 b=2 op=11 -> grants alternate 0,1,0,1; responses 12 then -4, overflow 0.
REQ-026 rsp_ready held low 5 cycles in RESP -> rsp_* stable all 5 cycles, both reqN_ready low, one response only after rsp_ready rises.
REQ-027 rst_n pulsed low during WAIT -> rsp_valid stays 0, all outputs at reset values, next req0 accept completes normally.
REQ-028 CALC_LAT=3, req0 a=127 b=-128 op=01 -> rsp_valid 4 cycles after accept, rsp_result=-1, rsp_overflow=1.
